// File: rtl/booth_radix4_mult_if.sv
// Load/done handshake bundle for the radix-4 Booth multiplier.
interface booth_radix4_mult_if #(
  parameter int WIDTH = 8
);
  logic                 load;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  modport master (
    output load, is_signed, a, b,
    input  ready, busy, product, done
  );

  modport slave (
    input  load, is_signed, a, b,
    output ready, busy, product, done
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 modified-Booth multiplier, two multiplier bits per clock.
// Signed or unsigned operands per operation; fixed latency of N_ITER edges.
module booth_radix4_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  booth_radix4_mult_if.slave bus
);

  localparam int N_ITER = WIDTH / 2 + 1;
  // Extended multiplier width: 2 extra bits so the top triplet carries the sign/zero.
  localparam int EW     = WIDTH + 2;
  // Accumulator high part: wide enough for +-2a plus carried partial sums.
  localparam int HW     = WIDTH + 4;
  // Full shift register: {accumulator, extended multiplier, implicit b[-1]}.
  localparam int PW     = HW + EW + 1;
  localparam int CW     = $clog2(N_ITER + 1);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_radix4_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [HW-1:0]        r_a;
  logic [PW-1:0]        r_p;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last;
  logic [HW-1:0]        w_a_ext;
  logic [EW-1:0]        w_b_ext;
  logic [HW-1:0]        w_addend;
  logic [HW-1:0]        w_hi_sum;
  logic [PW-1:0]        w_p_sum;
  logic [PW-1:0]        w_p_shift;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_done;

  assign w_accept = (r_state == S_IDLE) && bus.load;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N_ITER - 1));

  assign w_a_ext  = {{(HW - WIDTH){bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
  assign w_b_ext  = {{(EW - WIDTH){bus.is_signed & bus.b[WIDTH-1]}}, bus.b};

  // Booth recoding of the current low triplet into a multiple of the multiplicand.
  always_comb begin
    w_addend = '0;
    case (r_p[2:0])
      3'b001, 3'b010: w_addend = r_a;
      3'b011:         w_addend = r_a << 1;
      3'b100:         w_addend = -(r_a << 1);
      3'b101, 3'b110: w_addend = -r_a;
      default:        w_addend = '0;
    endcase
  end

  // Add into the high part, then arithmetic shift the whole register by 2;
  // after N_ITER steps the exact product sits in r_p[PW-1:1].
  assign w_hi_sum  = r_p[PW-1:EW+1] + w_addend;
  assign w_p_sum   = {w_hi_sum, r_p[EW:0]};
  assign w_p_shift = {{2{w_p_sum[PW-1]}}, w_p_sum[PW-1:2]};

  // Datapath: capture operands on accept, iterate in RUN, latch result on last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= w_a_ext;
      r_p   <= {{HW{1'b0}}, w_b_ext, 1'b0};
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_shift;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_product <= w_p_shift[2*WIDTH:1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; load is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.load) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_RUN:   w_busy  = 1'b1;
      S_DONE:  begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: w_ready = 1'b1;
    endcase
  end

  assign bus.ready   = w_ready;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult at WIDTH 8, 16 and 4.
module tb_booth_radix4_mult;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  booth_radix4_mult_if #(.WIDTH(8))  if8  ();
  booth_radix4_mult_if #(.WIDTH(16)) if16 ();
  booth_radix4_mult_if #(.WIDTH(4))  if4  ();

  booth_radix4_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  booth_radix4_mult #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  booth_radix4_mult #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t q4[$];

  function automatic int wid(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 4;
  endfunction

  function automatic logic [63:0] mask(input int bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_mul(input int w, input bit s, input longint a, input longint b);
    longint x;
    longint y;
    x = a & longint'(mask(w));
    y = b & longint'(mask(w));
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y) & mask(2 * w);
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? if8.ready : (sel == 1) ? if16.ready : if4.ready;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if8.busy : (sel == 1) ? if16.busy : if4.busy;
  endfunction

  task automatic set_in(input int sel, input logic ld, input logic s, input longint a, input longint b);
    case (sel)
      0: begin if8.load = ld;  if8.is_signed = s;  if8.a = a[7:0];   if8.b = b[7:0];   end
      1: begin if16.load = ld; if16.is_signed = s; if16.a = a[15:0]; if16.b = b[15:0]; end
      default: begin if4.load = ld; if4.is_signed = s; if4.a = a[3:0]; if4.b = b[3:0]; end
    endcase
  endtask

  task automatic push(input int sel, input logic [63:0] exp);
    exp_t e;
    e.exp = exp & mask(2 * wid(sel));
    e.acc = cyc;
    case (sel)
      0:       q8.push_back(e);
      1:       q16.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  task automatic mon(input int sel, input logic [63:0] prod);
    exp_t e;
    int   qs;
    int   w;
    w  = wid(sel);
    qs = (sel == 0) ? q8.size() : (sel == 1) ? q16.size() : q4.size();
    n_checks++;
    if (qs == 0) begin
      n_errors++;
      $display("FAIL unexpected_done_w%0d: got done with %0d pending, expected at least 1", w, qs);
      return;
    end
    case (sel)
      0:       e = q8.pop_front();
      1:       e = q16.pop_front();
      default: e = q4.pop_front();
    endcase
    chk($sformatf("product_w%0d", w), prod, e.exp);
    chk($sformatf("latency_w%0d", w), 64'(cyc - e.acc), 64'(w / 2 + 1));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (if8.done  === 1'b1) mon(0, 64'(if8.product));
        if (if16.done === 1'b1) mon(1, 64'(if16.product));
        if (if4.done  === 1'b1) mon(2, 64'(if4.product));
      end
    end
  end

  // Single operation: wait for ready, issue, scramble inputs, then check busy window.
  task automatic do_op(input int sel, input bit s, input longint a, input longint b, input logic [63:0] exp);
    int t;
    int bcnt;
    int w;
    w = wid(sel);
    @(negedge clk);
    t = 0;
    while (!get_ready(sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("ready_before_load_w%0d", w), 64'(get_ready(sel)), 64'd1);
    set_in(sel, 1'b1, s, a, b);
    @(posedge clk);
    #1;
    push(sel, exp);
    @(negedge clk);
    set_in(sel, 1'b0, ~s, ~a, ~b);
    bcnt = 0;
    t = 0;
    while (get_busy(sel) && t < 100) begin
      chk($sformatf("ready_low_while_busy_w%0d", w), 64'(get_ready(sel)), 64'd0);
      bcnt++;
      @(negedge clk);
      t++;
    end
    chk($sformatf("busy_cycles_w%0d", w), 64'(bcnt), 64'(w / 2 + 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int a1;
    set_in(0, 1'b0, 1'b0, 0, 0);
    set_in(1, 1'b0, 1'b0, 0, 0);
    set_in(2, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready",   64'(if8.ready),   64'd1);
    chk("reset_busy",    64'(if8.busy),    64'd0);
    chk("reset_done",    64'(if8.done),    64'd0);
    chk("reset_product", 64'(if8.product), 64'd0);
    rst = 1'b1;

    // WIDTH=8 directed vectors
    do_op(0, 1'b1,   10,   -2, 64'hFFEC);
    do_op(0, 1'b1, -128, -128, 64'h4000);
    do_op(0, 1'b1, -128,  127, 64'hC080);
    do_op(0, 1'b0, 8'hFF, 8'hFF, 64'hFE01);
    do_op(0, 1'b1, 8'hFF, 8'hFF, 64'h0001);
    do_op(0, 1'b0,    0, 8'hFF, 64'h0000);
    do_op(0, 1'b1,  127,  127, 64'h3F01);

    // load held high across the whole operation; operand change mid-run
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 3, 7);
    @(posedge clk);
    #1;
    push(0, 64'd21);
    a1 = cyc;
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 5, 7);
    t = 0;
    while (!if8.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    push(0, 64'd35);
    chk("reaccept_edge_distance", 64'(cyc - a1), 64'd7);
    chk("reaccept_ready_low", 64'(if8.ready), 64'd0);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 0, 0);
    t = 0;
    while (if8.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("held_load_back_to_idle", 64'(if8.ready), 64'd1);

    // reset two cycles into RUN aborts the operation
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, -5, -2);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 1'b1, -5, -2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_product", 64'(if8.product), 64'd0);
    chk("abort_ready",   64'(if8.ready),   64'd1);
    chk("abort_busy",    64'(if8.busy),    64'd0);
    chk("abort_done",    64'(if8.done),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(0, 1'b1, -5, -2, 64'd10);

    // WIDTH=16: corners plus random sweep against the reference multiply
    do_op(1, 1'b1, -32768, -32768, 64'h4000_0000);
    do_op(1, 1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE_0001);
    do_op(1, 1'b1, 16'hFFFF, 16'hFFFF, 64'h0000_0001);
    for (int i = 0; i < 40; i++) begin
      longint ra;
      longint rb;
      bit     rs;
      ra = longint'($urandom_range(0, 65535));
      rb = longint'($urandom_range(0, 65535));
      rs = i[0];
      do_op(1, rs, ra, rb, ref_mul(16, rs, ra, rb));
    end

    // WIDTH=4: exhaustive in both modes
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          do_op(2, s[0], longint'(ia), longint'(ib), ref_mul(4, s[0], longint'(ia), longint'(ib)));
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("pending_w8",  64'(q8.size()),  64'd0);
    chk("pending_w16", 64'(q16.size()), 64'd0);
    chk("pending_w4",  64'(q4.size()),  64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
